// File: rtl/frame_config_sequencer.sv
// rtl/frame_config_sequencer.sv - header+payload configuration word loader driving frame strobes
module frame_config_sequencer #(
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int FRAME_SELECT_WIDTH = 5,
  parameter int NUM_ROWS           = 4,
  parameter int STROBE_CYCLES      = 2
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [31:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [32*NUM_ROWS-1:0]        FrameData,
  output logic [FRAME_SELECT_WIDTH-1:0] FrameSelect,
  output logic                          FrameStrobe,
  output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe_I,
  output logic                          busy,
  output logic                          err,
  input  logic                          err_clr,
  output logic [15:0]                   frame_count
);

  localparam int IDX_W = (MAX_FRAMES_PER_COL > 1) ? $clog2(MAX_FRAMES_PER_COL) : 1;
  localparam int CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SC_W  = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(NUM_ROWS - 1);
  localparam logic [SC_W-1:0]  LAST_STROBE = SC_W'(STROBE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]                    state_q, state_d;
  logic [CNT_W-1:0]              word_cnt_q, word_cnt_d;
  logic [SC_W-1:0]               strobe_cnt_q, strobe_cnt_d;
  logic [IDX_W-1:0]              frame_idx_q;
  logic [32*NUM_ROWS-1:0]        frame_data_q;
  logic [FRAME_SELECT_WIDTH-1:0] frame_sel_q;
  logic                          strobe_q;
  logic [MAX_FRAMES_PER_COL-1:0] strobe_vec_q;
  logic                          err_q;
  logic [15:0]                   frame_count_q;

  logic hdr_marker_ok, hdr_col_ok, hdr_idx_ok, hdr_ok;
  logic hdr_accept, word_accept, err_set, strobe_start, strobe_end;
  logic unused_hdr_bits;

  // Header field decode; low byte of the header carries nothing for this block.
  assign hdr_marker_ok   = (s_data[31:24] == 8'hFA);
  assign hdr_col_ok      = ((s_data[23:16] >> FRAME_SELECT_WIDTH) == 8'd0);
  assign hdr_idx_ok      = ({24'd0, s_data[15:8]} < 32'(MAX_FRAMES_PER_COL));
  assign hdr_ok          = hdr_marker_ok && hdr_col_ok && hdr_idx_ok;
  assign unused_hdr_bits = ^s_data[7:0];

  assign s_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy    = (state_q != S_IDLE);

  // Next-state decode: header parse in IDLE, word count in LOAD, strobe length in STROBE.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    strobe_cnt_d = strobe_cnt_q;
    hdr_accept   = 1'b0;
    word_accept  = 1'b0;
    err_set      = 1'b0;
    strobe_start = 1'b0;
    strobe_end   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          if (hdr_ok) begin
            hdr_accept = 1'b1;
            word_cnt_d = '0;
            state_d    = S_LOAD;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          word_accept = 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            strobe_start = 1'b1;
            strobe_cnt_d = '0;
            state_d      = S_STROBE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      S_STROBE: begin
        if (strobe_cnt_q == LAST_STROBE) begin
          strobe_end = 1'b1;
          state_d    = S_GAP;
        end else begin
          strobe_cnt_d = strobe_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and counters.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      strobe_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      strobe_cnt_q <= strobe_cnt_d;
    end
  end

  // Header capture: column and frame index only move on a valid header.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      frame_sel_q <= '0;
      frame_idx_q <= '0;
    end else if (hdr_accept) begin
      frame_sel_q <= s_data[16 +: FRAME_SELECT_WIDTH];
      frame_idx_q <= s_data[8 +: IDX_W];
    end
  end

  // Payload capture into the slice addressed by the word counter; held otherwise.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      frame_data_q <= '0;
    end else if (word_accept) begin
      for (int k = 0; k < NUM_ROWS; k++) begin
        if (word_cnt_q == CNT_W'(k)) begin
          frame_data_q[32*k +: 32] <= s_data;
        end
      end
    end
  end

  // Strobe pair rises with STROBE entry and drops on the transition into GAP.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      strobe_q     <= 1'b0;
      strobe_vec_q <= '0;
    end else if (strobe_start) begin
      strobe_q     <= 1'b1;
      strobe_vec_q <= {{(MAX_FRAMES_PER_COL-1){1'b0}}, 1'b1} << frame_idx_q;
    end else if (strobe_end) begin
      strobe_q     <= 1'b0;
      strobe_vec_q <= '0;
    end
  end

  // Committed-frame counter, bumped once per frame on STROBE entry; wraps naturally.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      frame_count_q <= '0;
    end else if (strobe_start) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // Sticky header error; a new error on the clearing edge keeps it set.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign FrameData     = frame_data_q;
  assign FrameSelect   = frame_sel_q;
  assign FrameStrobe   = strobe_q;
  assign FrameStrobe_I = strobe_vec_q;
  assign err           = err_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// tb/tb_frame_config_sequencer.sv - scoreboard bench for frame_config_sequencer
module tb_frame_config_sequencer;

  logic         CLK;
  logic         resetn;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] FrameData;
  logic [4:0]   FrameSelect;
  logic         FrameStrobe;
  logic [19:0]  FrameStrobe_I;
  logic         busy;
  logic         err;
  logic         err_clr;
  logic [15:0]  frame_count;

  frame_config_sequencer #(
    .MAX_FRAMES_PER_COL(20),
    .FRAME_SELECT_WIDTH(5),
    .NUM_ROWS(4),
    .STROBE_CYCLES(2)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .FrameData(FrameData),
    .FrameSelect(FrameSelect),
    .FrameStrobe(FrameStrobe),
    .FrameStrobe_I(FrameStrobe_I),
    .busy(busy),
    .err(err),
    .err_clr(err_clr),
    .frame_count(frame_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   sel;
    logic [19:0]  stb;
    logic [15:0]  fc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] exp_fc  = 16'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp(input logic [4:0] sel, input logic [19:0] stb, input logic [127:0] data);
    exp_t e;
    exp_fc = exp_fc + 16'd1;
    e.data = data;
    e.sel  = sel;
    e.stb  = stb;
    e.fc   = exp_fc;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w);
    int   n;
    logic acc;
    s_data  = w;
    s_valid = 1'b1;
    n       = 0;
    acc     = 1'b0;
    while (!acc && n < 50) begin
      @(negedge CLK);
      acc = s_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] h, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    send_word(h);
    send_word(d0);
    send_word(d1);
    send_word(d2);
    send_word(d3);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1'b1, 1'b0);
  endtask

  // Monitor: pops one expected frame per strobe rising edge and checks strobe length.
  logic prev_stb = 1'b0;
  int   stb_len  = 0;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (!resetn) begin
      prev_stb = 1'b0;
      stb_len  = 0;
    end else begin
      if (FrameStrobe && !prev_stb) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_FrameData", FrameData, mon_e.data);
          chk("mon_FrameSelect", FrameSelect, mon_e.sel);
          chk("mon_FrameStrobe_I", FrameStrobe_I, mon_e.stb);
          chk("mon_frame_count", frame_count, mon_e.fc);
          chk("mon_s_ready_low", s_ready, 1'b0);
        end
        stb_len = 1;
      end else if (FrameStrobe) begin
        stb_len++;
      end else if (prev_stb) begin
        chk("mon_strobe_len", stb_len, 2);
        chk("mon_strobe_I_off", FrameStrobe_I, 20'h0);
      end
      prev_stb = FrameStrobe;
    end
  end

  logic [31:0] bad_hdrs [3];

  initial begin
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    err_clr = 1'b0;
    bad_hdrs[0] = 32'hFB03_0700;
    bad_hdrs[1] = 32'hFA03_1400;
    bad_hdrs[2] = 32'hFA20_0000;

    #2;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_FrameData", FrameData, 128'h0);
    chk("rst_FrameSelect", FrameSelect, 5'd0);
    chk("rst_FrameStrobe", FrameStrobe, 1'b0);
    chk("rst_FrameStrobe_I", FrameStrobe_I, 20'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_frame_count", frame_count, 16'h0);
    @(posedge CLK);
    @(posedge CLK);
    #1 resetn = 1'b1;

    // Basic back-to-back frame with cycle-exact strobe window.
    push_exp(5'd3, 20'h00080, 128'h44444444_33333333_22222222_11111111);
    send_frame(32'hFA03_0700, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    @(negedge CLK);
    chk("c5_strobe_I", FrameStrobe_I, 20'h00080);
    chk("c5_s_ready", s_ready, 1'b0);
    chk("c5_busy", busy, 1'b1);
    @(negedge CLK);
    chk("c6_strobe", FrameStrobe, 1'b1);
    chk("c6_s_ready", s_ready, 1'b0);
    @(negedge CLK);
    chk("c7_strobe", FrameStrobe, 1'b0);
    chk("c7_s_ready", s_ready, 1'b0);
    chk("c7_FrameData_held", FrameData, 128'h44444444_33333333_22222222_11111111);
    @(negedge CLK);
    chk("c8_s_ready", s_ready, 1'b1);
    chk("c8_frame_count", frame_count, 16'd1);
    chk("c8_FrameSelect", FrameSelect, 5'd3);

    // Invalid headers: marker, frame index 20, column 32.
    for (int i = 0; i < 3; i++) begin
      send_word(bad_hdrs[i]);
      s_valid = 1'b0;
      @(negedge CLK);
      chk("bad_err", err, 1'b1);
      chk("bad_busy", busy, 1'b0);
      chk("bad_FrameSelect", FrameSelect, 5'd3);
      chk("bad_strobe", FrameStrobe, 1'b0);
      @(posedge CLK);
      #1 err_clr = 1'b1;
      @(posedge CLK);
      #1 err_clr = 1'b0;
      chk("bad_err_cleared", err, 1'b0);
    end

    // Boundary header (column 31, index 19); a marker-looking data word stays data.
    push_exp(5'd31, 20'h80000, 128'h0BADF00D_FA010200_CAFEBABE_DEADBEEF);
    send_frame(32'hFA1F_1300, 32'hDEADBEEF, 32'hCAFEBABE, 32'hFA010200, 32'h0BADF00D);
    wait_idle();
    chk("b_frame_count", frame_count, 16'd2);
    chk("b_err", err, 1'b0);

    // Source stall between words 2 and 3.
    push_exp(5'd5, 20'h00001, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1);
    send_word(32'hFA05_0000);
    send_word(32'hA1A1A1A1);
    send_word(32'hA2A2A2A2);
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_strobe", FrameStrobe, 1'b0);
      chk("stall_partial", FrameData[63:0], 64'hA2A2A2A2_A1A1A1A1);
      chk("stall_old_upper", FrameData[127:64], 64'h0BADF00D_FA010200);
      @(posedge CLK);
      #1;
    end
    send_word(32'hA3A3A3A3);
    send_word(32'hA4A4A4A4);
    s_valid = 1'b0;
    wait_idle();
    chk("stall_frame_count", frame_count, 16'd3);

    // Reset during STROBE drops strobes immediately.
    send_frame(32'hFA02_0100, 32'h1, 32'h2, 32'h3, 32'h4);
    chk("pre_rst_strobe", FrameStrobe, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_strobe", FrameStrobe, 1'b0);
    chk("rst_mid_strobe_I", FrameStrobe_I, 20'h0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_fc", frame_count, 16'h0);
    exp_fc = 16'd0;
    @(posedge CLK);
    #1 resetn = 1'b1;
    push_exp(5'd4, 20'h00004, 128'h00000008_00000007_00000006_00000005);
    send_frame(32'hFA04_0200, 32'h5, 32'h6, 32'h7, 32'h8);
    wait_idle();
    chk("post_rst_fc", frame_count, 16'd1);

    // err_clr on the same edge as a bad header: set wins.
    err_clr = 1'b1;
    send_word(32'hFB00_0000);
    s_valid = 1'b0;
    err_clr = 1'b0;
    chk("clr_vs_set", err, 1'b1);
    @(posedge CLK);
    #1 err_clr = 1'b1;
    @(posedge CLK);
    #1 err_clr = 1'b0;
    chk("clr_alone", err, 1'b0);

    repeat (5) @(posedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
